brick_sched: RTL and testbench

- Sequencer/arbiter in front of the brick-grid storage (24x32 cells, 3-bit brick kind, funcs CLEAR/LOAD/DROP/PULL, busy flag).
- Shares the grid's single row/col/func port between three clients:
  - level loader, which streams a level from ROM;
  - ball-collision unit, which does hit read-modify-write;
  - row-drop timer.
- Tracks the remaining destructible brick count and flags level clear.

---
 rtl/brick_pkg.sv | 39 +++
 rtl/brick_sched_if.sv | 44 ++++
 rtl/brick_cursor.sv | 38 +++
 rtl/brick_sched.sv | 186 ++++++++++++++++++
 tb/tb_brick_sched.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brick_pkg.sv
// Shared constants, grid function codes and FSM states for the brick-grid scheduler.
package brick_pkg;

  localparam int ROWS   = 24;
  localparam int COLS   = 32;
  localparam int KIND_W = 3;
  localparam int LVL_W  = 4;
  localparam int CNT_W  = 10;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int IDX_W  = 10;

  localparam logic [KIND_W-1:0] HARD_KIND = 3'd7;

  typedef enum logic [1:0] {
    FUNC_CLEAR = 2'b00,
    FUNC_LOAD  = 2'b01,
    FUNC_DROP  = 2'b10,
    FUNC_PULL  = 2'b11
  } grid_func_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL_ADDR,
    ST_FILL_WR,
    ST_HIT_RD,
    ST_HIT_WR,
    ST_DROP_ISSUE,
    ST_SCAN,
    ST_ACK,
    ST_DONE
  } state_e;

  // Kinds 1..6 can be destroyed and are counted; 0 is empty, HARD_KIND is permanent.
  function automatic logic is_destructible(input logic [KIND_W-1:0] kind);
    return (kind != '0) && (kind != HARD_KIND);
  endfunction

endpackage

// File: rtl/brick_sched_if.sv
// Client, ROM and grid-port signals of brick_sched; slave is the scheduler's view.
interface brick_sched_if;
  import brick_pkg::*;

  logic                  fill_start;
  logic [LVL_W-1:0]      level_id;
  logic [LVL_W+9:0]      rom_addr;
  logic [KIND_W-1:0]     rom_data;
  logic                  fill_done;
  logic                  hit_req;
  logic [6:0]            hit_row;
  logic [6:0]            hit_col;
  logic                  hit_ack;
  logic [KIND_W-1:0]     hit_kind;
  logic                  hit_destroyed;
  logic                  drop_req;
  logic                  drop_ack;
  logic [6:0]            grid_row;
  logic [6:0]            grid_col;
  logic                  grid_enable;
  logic [1:0]            grid_func;
  logic [KIND_W-1:0]     grid_in;
  logic [KIND_W-1:0]     grid_out;
  logic                  grid_busy;
  logic [CNT_W-1:0]      brick_count;
  logic                  level_clear;
  logic                  sched_busy;

  modport slave (
    input  fill_start, level_id, rom_data, hit_req, hit_row, hit_col, drop_req,
           grid_out, grid_busy,
    output rom_addr, fill_done, hit_ack, hit_kind, hit_destroyed, drop_ack,
           grid_row, grid_col, grid_enable, grid_func, grid_in,
           brick_count, level_clear, sched_busy
  );

  modport master (
    output fill_start, level_id, rom_data, hit_req, hit_row, hit_col, drop_req,
           grid_out, grid_busy,
    input  rom_addr, fill_done, hit_ack, hit_kind, hit_destroyed, drop_ack,
           grid_row, grid_col, grid_enable, grid_func, grid_in,
           brick_count, level_clear, sched_busy
  );
endinterface

// File: rtl/brick_cursor.sv
// Row-major row/col walker over the grid, shared by the level fill and the post-drop recount.
module brick_cursor
  import brick_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_idx  = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);
  assign o_last = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_step) begin
      if (r_col == COL_W'(COLS - 1)) begin
        r_col <= '0;
        r_row <= o_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/brick_sched.sv
// Arbitrates the brick grid port between level fill, ball hits and row drops; tracks bricks left.
// Optional: define MULTI_HIT_EN so kinds 2..6 lose one level per hit instead of clearing at once.
module brick_sched
  import brick_pkg::*;
(
  input  logic         i_clock,
  input  logic         i_reset,
  brick_sched_if.slave bus
);

  state_e            r_state;
  logic [LVL_W-1:0]  r_level;
  logic [6:0]        r_hit_row;
  logic [6:0]        r_hit_col;
  logic [KIND_W-1:0] r_kind;
  logic [KIND_W-1:0] r_new_kind;
  logic              r_hit_wr;
  logic              r_destroy;
  logic [CNT_W-1:0]  r_tally;
  logic [CNT_W-1:0]  r_count;
  logic              r_level_clear;
  logic              r_hit_ack;
  logic              r_drop_ack;
  logic [KIND_W-1:0] r_hit_kind;
  logic              r_hit_destroyed;

  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last;
  logic              w_walking;
  logic              w_cur_step;
  logic [KIND_W-1:0] w_cell_kind;
  logic [CNT_W-1:0]  w_next_tally;
  logic              w_in_range;
  logic [KIND_W-1:0] w_rd_kind;
  logic [KIND_W-1:0] w_new_kind;
  logic [1:0]        w_grid_func;
  logic [KIND_W-1:0] w_grid_in;

  brick_cursor u_cursor (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (r_state == ST_IDLE),
    .i_step  (w_cur_step),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  assign w_walking    = (r_state == ST_FILL_ADDR) || (r_state == ST_FILL_WR) || (r_state == ST_SCAN);
  assign w_cur_step   = !bus.grid_busy && ((r_state == ST_FILL_WR) || (r_state == ST_SCAN));
  assign w_cell_kind  = (r_state == ST_FILL_WR) ? bus.rom_data : bus.grid_out;
  assign w_next_tally = r_tally + CNT_W'(is_destructible(w_cell_kind));
  assign w_in_range   = (r_hit_row < 7'(ROWS)) && (r_hit_col < 7'(COLS));
  assign w_rd_kind    = w_in_range ? bus.grid_out : '0;

`ifdef MULTI_HIT_EN
  assign w_new_kind = (w_rd_kind > KIND_W'(1)) ? w_rd_kind - 1'b1 : '0;
`else
  assign w_new_kind = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_grid_func = FUNC_CLEAR;
    w_grid_in   = '0;
    case (r_state)
      ST_FILL_ADDR:  w_grid_func = FUNC_LOAD;
      ST_FILL_WR: begin
        w_grid_func = FUNC_LOAD;
        w_grid_in   = bus.rom_data;
      end
      ST_HIT_RD:     w_grid_func = FUNC_LOAD;
      ST_HIT_WR: begin
        w_grid_func = r_destroy ? FUNC_CLEAR : FUNC_LOAD;
        w_grid_in   = r_new_kind;
      end
      ST_DROP_ISSUE: w_grid_func = FUNC_DROP;
      default: ;
    endcase
  end

  assign bus.grid_enable = !bus.grid_busy &&
                           ((r_state == ST_FILL_WR) || (r_state == ST_DROP_ISSUE) ||
                            ((r_state == ST_HIT_WR) && r_hit_wr));
  assign bus.grid_row      = w_walking ? 7'(w_row) : r_hit_row;
  assign bus.grid_col      = w_walking ? 7'(w_col) : r_hit_col;
  assign bus.grid_func     = w_grid_func;
  assign bus.grid_in       = w_grid_in;
  assign bus.rom_addr      = {r_level, w_idx};
  assign bus.fill_done     = (r_state == ST_DONE);
  assign bus.sched_busy    = (r_state != ST_IDLE);
  assign bus.hit_ack       = r_hit_ack;
  assign bus.hit_kind      = r_hit_kind;
  assign bus.hit_destroyed = r_hit_destroyed;
  assign bus.drop_ack      = r_drop_ack;
  assign bus.brick_count   = r_count;
  assign bus.level_clear   = r_level_clear;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_level         <= '0;
      r_hit_row       <= '0;
      r_hit_col       <= '0;
      r_kind          <= '0;
      r_new_kind      <= '0;
      r_hit_wr        <= 1'b0;
      r_destroy       <= 1'b0;
      r_tally         <= '0;
      r_count         <= '0;
      r_level_clear   <= 1'b0;
      r_hit_ack       <= 1'b0;
      r_drop_ack      <= 1'b0;
      r_hit_kind      <= '0;
      r_hit_destroyed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tally <= '0;
          if (bus.fill_start) begin
            r_level       <= bus.level_id;
            r_level_clear <= 1'b0;
            r_state       <= ST_FILL_ADDR;
          end else if (bus.drop_req) begin
            r_state <= ST_DROP_ISSUE;
          end else if (bus.hit_req) begin
            r_hit_row <= bus.hit_row;
            r_hit_col <= bus.hit_col;
            r_state   <= ST_HIT_RD;
          end
        end
        ST_FILL_ADDR: r_state <= ST_FILL_WR;
        ST_FILL_WR: if (!bus.grid_busy) begin
          r_tally <= w_next_tally;
          if (w_last) begin
            r_count <= w_next_tally;
            if (w_next_tally == '0) r_level_clear <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_FILL_ADDR;
          end
        end
        ST_HIT_RD: if (!bus.grid_busy) begin
          r_kind     <= w_rd_kind;
          r_new_kind <= w_new_kind;
          r_hit_wr   <= is_destructible(w_rd_kind);
          r_destroy  <= is_destructible(w_rd_kind) && (w_new_kind == '0);
          r_state    <= ST_HIT_WR;
        end
        ST_HIT_WR: if (!bus.grid_busy) begin
          r_hit_ack       <= 1'b1;
          r_hit_kind      <= r_kind;
          r_hit_destroyed <= r_destroy;
          if (r_destroy && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
            if (r_count == CNT_W'(1)) r_level_clear <= 1'b1;
          end
          r_state <= ST_ACK;
        end
        ST_DROP_ISSUE: if (!bus.grid_busy) r_state <= ST_SCAN;
        ST_SCAN: if (!bus.grid_busy) begin
          r_tally <= w_next_tally;
          if (w_last) begin
            r_count <= w_next_tally;
            if ((w_next_tally == '0) && (r_count != '0)) r_level_clear <= 1'b1;
            r_drop_ack <= 1'b1;
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_hit_ack       <= 1'b0;
          r_drop_ack      <= 1'b0;
          r_hit_kind      <= '0;
          r_hit_destroyed <= 1'b0;
          r_state         <= ST_IDLE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_sched.sv
// Directed bench for brick_sched with behavioural grid and level ROM; honours MULTI_HIT_EN.
module tb_brick_sched;
  import brick_pkg::*;

`ifdef MULTI_HIT_EN
  localparam int MH = 1;
`else
  localparam int MH = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   bad_en = 0;

  brick_sched_if bus();

  brick_sched dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  logic [2:0] grid    [ROWS][COLS];
  logic [2:0] rom_mem [1024];
  logic [2:0] rom_q = 3'd0;

  assign bus.rom_data = rom_q;
  assign bus.grid_out = (bus.grid_row < 7'd24 && bus.grid_col < 7'd32) ?
                        grid[bus.grid_row[4:0]][bus.grid_col[4:0]] : 3'd0;

  // Level ROM: only level 5 holds bricks, data follows the address by one clock.
  always @(posedge clock)
    rom_q <= (bus.rom_addr[13:10] == 4'd5) ? rom_mem[bus.rom_addr[9:0]] : 3'd0;

  always @(posedge clock) begin
    if (bus.grid_enable) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.grid_busy) bad_en <= bad_en + 1;
      case (bus.grid_func)
        2'b00: if (bus.grid_row < 7'd24 && bus.grid_col < 7'd32)
                 grid[bus.grid_row[4:0]][bus.grid_col[4:0]] <= 3'd0;
        2'b01: if (bus.grid_row < 7'd24 && bus.grid_col < 7'd32)
                 grid[bus.grid_row[4:0]][bus.grid_col[4:0]] <= bus.grid_in;
        2'b10: begin
          for (int r = ROWS - 1; r > 0; r--)
            for (int c = 0; c < COLS; c++) grid[r][c] <= grid[r-1][c];
          for (int c = 0; c < COLS; c++) grid[0][c] <= 3'd0;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic do_hit(input int row, input int col, output logic [2:0] kind,
                        output logic dest, output int lat);
    @(negedge clock);
    bus.hit_req = 1'b1;
    bus.hit_row = 7'(row);
    bus.hit_col = 7'(col);
    lat = 0;
    while (!bus.hit_ack && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!bus.hit_ack) check("hit_ack_timeout", 0, 1);
    kind = bus.hit_kind;
    dest = bus.hit_destroyed;
    bus.hit_req = 1'b0;
  endtask

  task automatic do_fill(input logic [3:0] lvl, output int cyc, output logic lc_start);
    @(negedge clock);
    bus.fill_start = 1'b1;
    bus.level_id   = lvl;
    @(negedge clock);
    bus.fill_start = 1'b0;
    lc_start = bus.level_clear;
    cyc = 1;
    while (!bus.fill_done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    check("fill_done_seen", bus.fill_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] kind;
    logic       dest;
    logic       lc;
    logic       seen;
    logic       hit_first;
    int         lat;
    int         cyc;
    int         w0;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 3'd0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd0;
    rom_mem[0]   = 3'd3;  // (0,0)
    rom_mem[5]   = 3'd3;  // (0,5)
    rom_mem[33]  = 3'd7;  // (1,1) hard
    rom_mem[100] = 3'd3;  // (3,4)
    rom_mem[330] = 3'd3;  // (10,10)
    rom_mem[740] = 3'd3;  // (23,4)

    bus.fill_start = 1'b0;
    bus.level_id   = '0;
    bus.hit_req    = 1'b0;
    bus.hit_row    = '0;
    bus.hit_col    = '0;
    bus.drop_req   = 1'b0;
    bus.grid_busy  = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_brick_count", bus.brick_count, 0);
    check("rst_level_clear", bus.level_clear, 0);
    check("rst_sched_busy", bus.sched_busy, 0);
    check("rst_acks", {bus.fill_done, bus.hit_ack, bus.drop_ack, bus.hit_destroyed}, 0);
    check("rst_grid_port", {bus.grid_enable, bus.grid_func, bus.grid_row, bus.grid_col, bus.grid_in}, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    reset = 1'b0;

    // Level 5 fill.
    do_fill(4'd5, cyc, lc);
    check("fill_cycles", (cyc >= 1536 && cyc <= 1538), 1);
    check("fill_count", bus.brick_count, 5);
    check("fill_level_clear", bus.level_clear, 0);
    @(negedge clock);
    check("fill_done_pulse", bus.fill_done, 0);
    check("grid_0_0", grid[0][0], 3);
    check("grid_1_1", grid[1][1], 7);
    check("grid_3_4", grid[3][4], 3);

    // No-write hits: empty, hard, out of range.
    w0 = wr_cnt;
    do_hit(2, 2, kind, dest, lat);
    check("empty_kind", kind, 0);
    check("empty_dest", dest, 0);
    check("empty_lat", lat, 3);
    do_hit(1, 1, kind, dest, lat);
    check("hard_kind", kind, 7);
    check("hard_dest", dest, 0);
    check("hard_lat", lat, 3);
    do_hit(30, 0, kind, dest, lat);
    check("oor_kind", kind, 0);
    check("oor_dest", dest, 0);
    check("oor_lat", lat, 3);
    @(negedge clock);
    check("nowrite_count", wr_cnt - w0, 0);
    check("nowrite_bricks", bus.brick_count, 5);
    check("hard_cell_kept", grid[1][1], 7);

    // Destructible kind-3 cell at (0,5).
    w0 = wr_cnt;
    for (int i = 0; i <= 2 * MH; i++) begin
      do_hit(0, 5, kind, dest, lat);
      check("k3_kind", kind, 3 - i);
      check("k3_dest", dest, (i == 2 * MH) ? 1 : 0);
    end
    @(negedge clock);
    check("k3_writes", wr_cnt - w0, 1 + 2 * MH);
    check("k3_count", bus.brick_count, 4);
    check("k3_cell", grid[0][5], 0);

    // Grid busy for 10 cycles while reading (0,0).
    @(negedge clock);
    bus.hit_req = 1'b1;
    bus.hit_row = 7'd0;
    bus.hit_col = 7'd0;
    @(negedge clock);
    bus.grid_busy = 1'b1;
    w0   = wr_cnt;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bus.hit_ack) seen = 1'b1;
    end
    bus.grid_busy = 1'b0;
    check("busy_no_ack", seen, 0);
    check("busy_no_write", wr_cnt - w0, 0);
    lat = 0;
    while (!bus.hit_ack && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("busy_ack_after", bus.hit_ack, 1);
    check("busy_kind", bus.hit_kind, 3);
    check("busy_dest", bus.hit_destroyed, 1 - MH);
    bus.hit_req = 1'b0;
    @(negedge clock);
    check("busy_count", bus.brick_count, 3 + MH);

    // Drop and hit together: drop wins, row 23 brick is lost.
    @(negedge clock);
    bus.drop_req = 1'b1;
    bus.hit_req  = 1'b1;
    bus.hit_row  = 7'd4;
    bus.hit_col  = 7'd4;
    hit_first = 1'b0;
    cyc = 0;
    while (!bus.drop_ack && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (bus.hit_ack) hit_first = 1'b1;
    end
    check("drop_ack_seen", bus.drop_ack, 1);
    check("drop_before_hit", hit_first, 0);
    check("drop_recount", bus.brick_count, 2 + MH);
    bus.drop_req = 1'b0;
    lat = 0;
    while (!bus.hit_ack && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("post_drop_hit_ack", bus.hit_ack, 1);
    check("post_drop_kind", bus.hit_kind, 3);
    check("post_drop_dest", bus.hit_destroyed, 1 - MH);
    bus.hit_req = 1'b0;
    @(negedge clock);
    check("post_drop_count", bus.brick_count, 1 + 2 * MH);
    check("row23_lost", grid[23][4], 0);
    check("moved_brick", grid[11][10], 3);
    check("pre_clear_flag", bus.level_clear, 0);

    // Clear every remaining brick.
    begin
      int cells [3][2] = '{'{1, 0}, '{4, 4}, '{11, 10}};
      for (int k = 0; k < 3; k++) begin
        for (int n = 0; n < 8; n++) begin
          do_hit(cells[k][0], cells[k][1], kind, dest, lat);
          if (dest || kind == 3'd0) break;
        end
      end
    end
    @(negedge clock);
    check("clear_count", bus.brick_count, 0);
    check("clear_flag", bus.level_clear, 1);

    // fill_start during a hit is dropped.
    @(negedge clock);
    bus.hit_req = 1'b1;
    bus.hit_row = 7'd2;
    bus.hit_col = 7'd2;
    @(negedge clock);
    bus.fill_start = 1'b1;
    bus.level_id   = 4'd5;
    @(negedge clock);
    bus.fill_start = 1'b0;
    lat = 0;
    while (!bus.hit_ack && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("midhit_ack", bus.hit_ack, 1);
    bus.hit_req = 1'b0;
    repeat (3) @(negedge clock);
    check("midhit_fill_ignored", bus.sched_busy, 0);
    check("midhit_flag_kept", bus.level_clear, 1);

    // Accepted fill_start clears the flag; an empty level sets it again.
    do_fill(4'd2, cyc, lc);
    check("fill_start_clears", lc, 0);
    check("empty_fill_count", bus.brick_count, 0);
    check("empty_fill_flag", bus.level_clear, 1);

    // Reset in the middle of a fill.
    @(negedge clock);
    bus.fill_start = 1'b1;
    bus.level_id   = 4'd5;
    @(negedge clock);
    bus.fill_start = 1'b0;
    repeat (100) @(negedge clock);
    check("midfill_busy", bus.sched_busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("midfill_rst_outs", {bus.sched_busy, bus.fill_done, bus.grid_enable, bus.level_clear}, 0);
    check("midfill_rst_count", bus.brick_count, 0);
    check("midfill_rst_rom", bus.rom_addr, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (1700) begin
      @(negedge clock);
      if (bus.fill_done) seen = 1'b1;
    end
    check("midfill_no_done", seen, 0);
    check("midfill_idle", bus.sched_busy, 0);
    check("never_enable_busy", bad_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
